// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_pkg
//  Purpose  : Shared types for the DMEM port arbiter: arbitration states,
//             read-response owner tags and a small access-type helper.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

   // Arbitration state: CPU normally wins, ext can be forced in or hold a lock
   typedef enum logic [1:0] {
      CPU_PRI   = 2'd0,
      EXT_FORCE = 2'd1,
      EXT_LOCK  = 2'd2
   } arb_state_e;

   // Who receives the read data returned one cycle after a granted read
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_e;

   // An access with no byte enables set is a read
   function automatic logic is_read(input logic [3:0] we);
      return (we == 4'h0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_router.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_resp_router
//  Purpose  : Remembers which requester issued the read granted last cycle
//             and steers the DMEM read data to that requester only.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_resp_router
   import dmem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,          // synchronous, active-low
   input  logic        cpu_rd_i,     // CPU read granted this cycle
   input  logic        ext_rd_i,     // ext read granted this cycle
   input  logic [31:0] dmem_dout_i,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_rvalid_o,
   output logic [31:0] ext_rdata_o,
   output logic        ext_rvalid_o
);

   owner_e owner_q;

   // Owner tag is rewritten every cycle so back-to-back reads alternate freely
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q <= OWN_NONE;
      end else if (cpu_rd_i) begin
         owner_q <= OWN_CPU;
      end else if (ext_rd_i) begin
         owner_q <= OWN_EXT;
      end else begin
         owner_q <= OWN_NONE;
      end
   end

   // Demux read data; everything is suppressed while reset is held so a read
   // granted just before reset never reports a response
   always_comb begin
      cpu_rdata_o  = 32'h0;
      cpu_rvalid_o = 1'b0;
      ext_rdata_o  = 32'h0;
      ext_rvalid_o = 1'b0;
      if (rst) begin
         if (owner_q == OWN_CPU) begin
            cpu_rdata_o  = dmem_dout_i;
            cpu_rvalid_o = 1'b1;
         end else if (owner_q == OWN_EXT) begin
            ext_rdata_o  = dmem_dout_i;
            ext_rvalid_o = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares one synchronous DMEM port between the CPU M stage and an
//             external requester. CPU has priority; a starvation counter
//             forces an ext grant, and ext may lock the port for bursts.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int MAX_WAIT   = 8,
   parameter int LOCK_MAX   = 16
)(
   input  logic                  clk,
   input  logic                  rst,        // synchronous, active-low
   input  logic                  cpu_req,
   input  logic [3:0]            cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic                  cpu_stall,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_rvalid,
   input  logic                  ext_req,
   input  logic [3:0]            ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [31:0]           ext_wdata,
   input  logic                  ext_lock,
   output logic                  ext_gnt,
   output logic [31:0]           ext_rdata,
   output logic                  ext_rvalid,
   output logic                  dmem_en,
   output logic [3:0]            dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [31:0]           dmem_din,
   input  logic [31:0]           dmem_dout
);

   localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam int LOCK_W = $clog2(LOCK_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX);
   // A cap of one grant means the entry grant already exhausts the lock
   localparam logic LOCK_ALLOWED = (LOCK_MAX > 1);

   arb_state_e        state_q;
   arb_state_e        w_state;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic [LOCK_W-1:0] lock_cnt_q;
   logic [LOCK_W-1:0] w_lock_inc;
   logic              w_cpu_gnt;
   logic              w_ext_gnt;
   logic              w_enter_lock;

   // While reset is held the grant logic behaves as in the reset state
   assign w_state      = rst ? state_q : CPU_PRI;
   assign w_lock_inc   = lock_cnt_q + LOCK_W'(1);
   assign w_enter_lock = w_ext_gnt & ext_lock & LOCK_ALLOWED;

   // Grant decision: CPU first in CPU_PRI, ext first in the forced/locked states
   always_comb begin
      w_cpu_gnt = 1'b0;
      w_ext_gnt = 1'b0;
      case (w_state)
         EXT_FORCE, EXT_LOCK: begin
            w_ext_gnt = ext_req;
            w_cpu_gnt = cpu_req & ~ext_req;
         end
         default: begin
            w_cpu_gnt = cpu_req;
            w_ext_gnt = ~cpu_req & ext_req;
         end
      endcase
   end

   // Arbitration FSM with starvation and lock-length counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= CPU_PRI;
         wait_cnt_q <= '0;
         lock_cnt_q <= '0;
      end else begin
         if (w_ext_gnt || !ext_req) begin
            wait_cnt_q <= '0;
         end else if (wait_cnt_q != WAIT_LAST) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
         end

         case (state_q)
            CPU_PRI: begin
               if (w_enter_lock) begin
                  state_q    <= EXT_LOCK;
                  lock_cnt_q <= LOCK_W'(1);
               end else if (ext_req && !w_ext_gnt && (wait_cnt_q == WAIT_LAST)) begin
                  state_q <= EXT_FORCE;
               end
            end
            EXT_FORCE: begin
               if (w_enter_lock) begin
                  state_q    <= EXT_LOCK;
                  lock_cnt_q <= LOCK_W'(1);
               end else begin
                  state_q    <= CPU_PRI;
                  lock_cnt_q <= '0;
               end
            end
            EXT_LOCK: begin
               if (!w_ext_gnt || !ext_lock || (w_lock_inc == LOCK_LAST)) begin
                  state_q    <= CPU_PRI;
                  lock_cnt_q <= '0;
               end else begin
                  lock_cnt_q <= w_lock_inc;
               end
            end
            default: begin
               state_q    <= CPU_PRI;
               lock_cnt_q <= '0;
            end
         endcase
      end
   end

   // DMEM port mux from the granted requester; quiet when nobody is granted
   always_comb begin
      dmem_en   = 1'b0;
      dmem_we   = 4'h0;
      dmem_addr = '0;
      dmem_din  = 32'h0;
      if (w_cpu_gnt) begin
         dmem_en   = 1'b1;
         dmem_we   = cpu_we;
         dmem_addr = cpu_addr;
         dmem_din  = cpu_wdata;
      end else if (w_ext_gnt) begin
         dmem_en   = 1'b1;
         dmem_we   = ext_we;
         dmem_addr = ext_addr;
         dmem_din  = ext_wdata;
      end
   end

   assign cpu_stall = cpu_req & ~w_cpu_gnt;
   assign ext_gnt   = w_ext_gnt;

   dmem_resp_router u_resp_router (
      .clk          (clk),
      .rst          (rst),
      .cpu_rd_i     (w_cpu_gnt & is_read(cpu_we)),
      .ext_rd_i     (w_ext_gnt & is_read(ext_we)),
      .dmem_dout_i  (dmem_dout),
      .cpu_rdata_o  (cpu_rdata),
      .cpu_rvalid_o (cpu_rvalid),
      .ext_rdata_o  (ext_rdata),
      .ext_rvalid_o (ext_rvalid)
   );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed scoreboard bench for dmem_arbiter. Each cycle states
//             the expected winner; read responses are queued and compared
//             on the following cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, ext_req, ext_lock;
   logic [3:0]    cpu_we, ext_we;
   logic [AW-1:0] cpu_addr, ext_addr;
   logic [31:0]   cpu_wdata, ext_wdata;
   logic          cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, dmem_en;
   logic [31:0]   cpu_rdata, ext_rdata, dmem_din;
   logic [3:0]    dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [31:0]   dmem_dout = 32'h0;

   typedef struct {
      owner_e      own;
      logic [31:0] data;
   } resp_t;

   resp_t sb_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(8), .LOCK_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
      .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
      .dmem_dout(dmem_dout)
   );

   // Memory contents as seen by the bench: address 0x10 holds 0xDEADBEEF
   function automatic logic [31:0] mdata(input logic [AW-1:0] a);
      if (a == 14'h10) return 32'hDEADBEEF;
      return {16'hC0DE, 2'b00, a};
   endfunction

   // Synchronous DMEM model: read data appears the cycle after an enabled read
   always @(posedge clk) begin
      dmem_dout <= (dmem_en && dmem_we == 4'h0) ? mdata(dmem_addr) : 32'hA5A5A5A5;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at a falling edge with inputs already applied; g names the
   // expected winner this cycle (0 none, 1 cpu, 2 ext)
   task automatic step(input int g, input string tag);
      resp_t         r;
      logic          ee;
      logic [3:0]    ew;
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      #1;
      if (sb_q.size() > 0) r = sb_q.pop_front();
      else r = '{OWN_NONE, 32'h0};
      if (!rst) r.own = OWN_NONE;
      chk({tag, "/cpu_rvalid"}, 32'(cpu_rvalid), 32'(r.own == OWN_CPU));
      chk({tag, "/cpu_rdata"},  cpu_rdata, (r.own == OWN_CPU) ? r.data : 32'h0);
      chk({tag, "/ext_rvalid"}, 32'(ext_rvalid), 32'(r.own == OWN_EXT));
      chk({tag, "/ext_rdata"},  ext_rdata, (r.own == OWN_EXT) ? r.data : 32'h0);

      ee = (g != 0);
      ew = (g == 1) ? cpu_we    : (g == 2) ? ext_we    : 4'h0;
      ea = (g == 1) ? cpu_addr  : (g == 2) ? ext_addr  : '0;
      ed = (g == 1) ? cpu_wdata : (g == 2) ? ext_wdata : 32'h0;
      chk({tag, "/ext_gnt"},   32'(ext_gnt),   32'(g == 2));
      chk({tag, "/cpu_stall"}, 32'(cpu_stall), 32'(cpu_req && g != 1));
      chk({tag, "/dmem_en"},   32'(dmem_en),   32'(ee));
      chk({tag, "/dmem_we"},   32'(dmem_we),   32'(ew));
      chk({tag, "/dmem_addr"}, 32'(dmem_addr), 32'(ea));
      chk({tag, "/dmem_din"},  dmem_din,       ed);

      if (rst && g == 1 && cpu_we == 4'h0)      sb_q.push_back('{OWN_CPU, mdata(cpu_addr)});
      else if (rst && g == 2 && ext_we == 4'h0) sb_q.push_back('{OWN_EXT, mdata(ext_addr)});
      else                                      sb_q.push_back('{OWN_NONE, 32'h0});
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
      cpu_we = 4'h0; ext_we = 4'h0; cpu_addr = '0; ext_addr = '0;
      cpu_wdata = 32'h0; ext_wdata = 32'h0;
      @(negedge clk);

      // Reset held with both requesting: no responses, CPU side of the mux
      cpu_req = 1'b1; ext_req = 1'b1; cpu_addr = 14'h100; ext_addr = 14'h200;
      step(1, "rst0");
      step(1, "rst1");
      rst = 1'b1;

      // Starvation: eight CPU wins, forced ext grant on the ninth, CPU again
      for (int i = 0; i < 8; i++) begin
         cpu_addr = 14'(14'h100 + i);
         step(1, "starve_cpu");
      end
      cpu_addr = 14'h108;
      step(2, "starve_ext");
      cpu_addr = 14'h109;
      step(1, "starve_regrant");

      // CPU read of 0x10, response checked on the idle cycle
      ext_req = 1'b0; cpu_addr = 14'h10;
      step(1, "cpu_rd");
      cpu_req = 1'b0;
      step(0, "idle");

      // Ext write with the CPU idle, then a CPU partial write
      ext_req = 1'b1; ext_we = 4'hF; ext_wdata = 32'h12345678; ext_addr = 14'h55;
      step(2, "ext_wr");
      ext_req = 1'b0; ext_we = 4'h0;
      cpu_req = 1'b1; cpu_we = 4'h3; cpu_wdata = 32'hCAFEF00D; cpu_addr = 14'h66;
      step(1, "cpu_wr");

      // Alternating reads by CPU then ext
      cpu_we = 4'h0; cpu_addr = 14'h20;
      step(1, "alt_cpu");
      cpu_req = 1'b0; ext_req = 1'b1; ext_addr = 14'h30;
      step(2, "alt_ext");
      ext_req = 1'b0;
      step(0, "alt_idle");

      // Lock ended by a beat with ext_lock low
      ext_req = 1'b1; ext_lock = 1'b1; ext_addr = 14'h40;
      step(2, "lk_b0");
      cpu_req = 1'b1; cpu_addr = 14'h21; ext_addr = 14'h41;
      step(2, "lk_b1");
      ext_lock = 1'b0; ext_addr = 14'h42;
      step(2, "lk_b2");
      ext_addr = 14'h43;
      step(1, "lk_after");
      ext_req = 1'b0;
      step(1, "lk_after2");

      // Lock ended by ext dropping its request
      cpu_req = 1'b0; ext_req = 1'b1; ext_lock = 1'b1; ext_addr = 14'h44;
      step(2, "lkd_b0");
      cpu_req = 1'b1; ext_req = 1'b0;
      step(1, "lkd_drop");
      ext_req = 1'b1; ext_lock = 1'b0;
      step(1, "lkd_cpu");
      ext_req = 1'b0;
      step(1, "lkd_clr");

      // Lock cap: forced entry, sixteen ext reads, CPU on the seventeenth
      ext_req = 1'b1; ext_lock = 1'b1; cpu_addr = 14'h22;
      for (int i = 0; i < 8; i++) step(1, "cap_cpu");
      for (int i = 0; i < 16; i++) begin
         ext_addr = 14'(14'h300 + i);
         step(2, "cap_ext");
      end
      step(1, "cap_cpu17");
      ext_req = 1'b0; ext_lock = 1'b0;
      step(1, "cap_tail");

      // A read granted right before reset must not produce a response
      cpu_addr = 14'h77;
      step(1, "pre_rst_rd");
      rst = 1'b0;
      step(1, "rst_kill");
      rst = 1'b1; cpu_req = 1'b0;
      step(0, "post_rst");
      step(0, "drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous DMEM port between two requesters:
  - the CPU M-stage load/store path (address already resolved by the ALU or by M-stage address forwarding);
  - an external requester (bootloader/DMA), `ext`.
- The CPU has priority. A starvation counter guarantees `ext` forward progress, and `ext` can lock the port for bursts.
- The block stalls the CPU pipeline when the CPU loses arbitration, and routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 14, DMEM word-address width.
- MAX_WAIT, 8, number of consecutive cycles `ext` may be denied before a forced grant (>=1).
- LOCK_MAX, 16, maximum consecutive locked `ext` grants before the CPU regains priority (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- cpu_req  in  1  CPU M-stage access request (load or store)
- cpu_we  in  4  CPU byte write enables; 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU denied this cycle; pipeline must hold M stage
- cpu_rdata  out  32  read data for CPU
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a granted CPU read)
- ext_req  in  1  external access request; held until granted
- ext_we  in  4  external byte write enables
- ext_addr  in  ADDR_WIDTH  external word address
- ext_wdata  in  32  external write data
- ext_lock  in  1  request to keep the port for the next beat
- ext_gnt  out  1  external access accepted this cycle
- ext_rdata  out  32  read data for ext
- ext_rvalid  out  1  ext_rdata valid
- dmem_en  out  1  DMEM enable
- dmem_we  out  4  DMEM byte write enables
- dmem_addr  out  ADDR_WIDTH  DMEM address
- dmem_din  out  32  DMEM write data
- dmem_dout  in  32  DMEM read data (valid one cycle after enable)

Behaviour:

States: CPU_PRI, EXT_FORCE, EXT_LOCK.

- **CPU_PRI**
  - cpu_req=1 → CPU granted.
  - cpu_req=0 and ext_req=1 → ext granted.
  - Transitions:
    - ext denied for MAX_WAIT consecutive cycles (wait_cnt == MAX_WAIT-1 and ext still denied) → EXT_FORCE.
    - ext granted with ext_lock=1 → EXT_LOCK.
- **EXT_FORCE**
  - ext granted regardless of cpu_req; cpu_stall = cpu_req.
  - Next state: EXT_LOCK if ext_lock=1, else CPU_PRI.
  - If ext_req has dropped, the state returns to CPU_PRI and the CPU is granted normally.
- **EXT_LOCK**
  - ext granted while ext_req=1; cpu_stall = cpu_req.
  - Leave to CPU_PRI when any of:
    - a granted beat has ext_lock=0;
    - ext_req=0 (no grant that cycle; CPU is served instead);
    - lock_cnt reaches LOCK_MAX grants.
- **Grant and port muxing**
  - Combinational from current state and requests; exactly one requester is granted per cycle, or none.
  - dmem_en=1 iff a grant occurs; dmem_we/addr/din come from the granted requester.
  - When no grant: dmem_we=0 and addr/din hold 0.
- **Stall, counters**
  - cpu_stall = cpu_req & ~cpu_granted.
  - wait_cnt clears on any ext grant or when ext_req=0, and saturates.
  - lock_cnt clears on entry to CPU_PRI.
- **Read response**
  - A registered owner tag (none/cpu/ext) is set when a granted access has we==0.
  - The next cycle, the owner's rvalid=1 and its rdata = dmem_dout. The non-owner's rdata = 0 and rvalid = 0.
  - Writes produce no rvalid.
  - Back-to-back reads by alternating requesters are allowed; the tag updates every cycle.
- **Reset** (rst=0 on a clock edge)
  - state=CPU_PRI, wait_cnt=0, lock_cnt=0, owner=none.
  - Outputs during reset are combinational from the reset state: rvalids are 0. No pending read response survives reset; a read granted the cycle before reset produces no rvalid.
- **Simultaneous requests**
  - Simultaneous cpu_req/ext_req in CPU_PRI: CPU wins; wait_cnt increments.
  - Requests with we≠0 and we==0 are treated identically for arbitration.

Decomposition:
- Shared package/header (alongside the opcode and select definitions):
  - state encodings (CPU_PRI=2'd0, EXT_FORCE=2'd1, EXT_LOCK=2'd2);
  - owner tag encodings (OWN_NONE, OWN_CPU, OWN_EXT).
- One natural sub-module: `dmem_resp_router` (owner tag register plus rdata/rvalid demux).
- The arbiter FSM and counters stay in the top.

Test Plan:
- **Reset:** rst=0 for 2 cycles with cpu_req=ext_req=1 → no rvalid in any cycle; after release, CPU granted first, cpu_stall=0.
- **CPU read:** cpu_req=1, cpu_we=0, addr=0x10, dmem_dout=0xDEADBEEF next cycle → cpu_rvalid=1 with cpu_rdata=0xDEADBEEF; ext_rvalid=0.
- **Starvation:** MAX_WAIT=8, cpu_req and ext_req held high → ext_gnt=1 and cpu_stall=1 on the 9th cycle only; the CPU is then regranted.
- **Idle CPU:** ext write with cpu_req=0, ext_we=4'hF, ext_wdata=0x12345678 → same-cycle ext_gnt=1, dmem_we=4'hF, dmem_din=0x12345678, no rvalid.
- **Lock cap:** LOCK_MAX=16, ext locked read burst while cpu_req=1 → 16 consecutive ext grants, each followed by ext_rvalid; CPU granted on the 17th cycle.
- **Alternating reads:** CPU read then ext read in consecutive cycles → cpu_rvalid then ext_rvalid on consecutive cycles with the correct data each.
